// File: rtl/vdp_reg_file_ifce.sv
// vdp_reg_file_ifce: VDP control-port register interface.
// Decodes the two-byte control write sequence into register writes, indirect
// pointer loads and VRAM address setups, and adds an auto-incrementing
// indirect register write port with per-register writable-bit masks.
module vdp_reg_file_ifce #(
    parameter int unsigned AW    = 3,
    parameter logic [511:0] WMASK = {64{8'hFF}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_tick,
    input  logic                 rd_tick,
    input  logic                 ind_wr_tick,
    input  logic [7:0]           din,
    output logic [(8<<AW)-1:0]   regs,
    output logic                 reg_wr_tick,
    output logic [AW-1:0]        reg_wr_idx,
    output logic [AW-1:0]        ptr,
    output logic [13:0]          vaddr,
    output logic                 vaddr_tick,
    output logic                 vaddr_wr
);

    localparam int unsigned NUM_REGS = 1 << AW;

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     w0;
    logic           autoinc;

    logic           latch_w0_c;
    logic           reg_wr_c;
    logic           ptr_ld_c;
    logic           vaddr_ld_c;
    logic [AW-1:0]  ctrl_idx_c;

    // Pairing state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Pairing next state and second-byte command decode.
    // A status read forces FIRST, but a coincident write still acts on the
    // state held before the read.
    always_comb begin
        state_nxt  = state;
        latch_w0_c = 1'b0;
        reg_wr_c   = 1'b0;
        ptr_ld_c   = 1'b0;
        vaddr_ld_c = 1'b0;
        ctrl_idx_c = din[AW-1:0];

        if (wr_tick) begin
            if (state == ST_FIRST) begin
                latch_w0_c = 1'b1;
                state_nxt  = ST_SECOND;
            end else begin
                state_nxt = ST_FIRST;
                if (din[7:6] == 2'b10) begin
                    // Out-of-range indices are dropped instead of aliasing.
                    reg_wr_c = (7'(din[5:0]) < 7'(NUM_REGS));
                end else if (din[7:6] == 2'b11) begin
                    ptr_ld_c = 1'b1;
                end else begin
                    vaddr_ld_c = 1'b1;
                end
            end
        end

        if (rd_tick) begin
            state_nxt = ST_FIRST;
        end
    end

    // First byte of a control pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w0 <= 8'h00;
        end else if (latch_w0_c) begin
            w0 <= din;
        end
    end

    // Register file; the control-port write takes priority over an indirect
    // write aimed at the same register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (reg_wr_c && (ctrl_idx_c == AW'(i))) begin
                    regs[i*8 +: 8] <= w0 & WMASK[i*8 +: 8];
                end else if (ind_wr_tick && (ptr == AW'(i))) begin
                    regs[i*8 +: 8] <= din & WMASK[i*8 +: 8];
                end
            end
        end
    end

    // Indirect pointer and auto-increment mode; a load overrides the increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            autoinc <= 1'b1;
        end else if (ptr_ld_c) begin
            ptr     <= din[AW-1:0];
            autoinc <= ~din[5];
        end else if (ind_wr_tick && autoinc) begin
            ptr <= ptr + AW'(1);
        end
    end

    // Register update notification; the control index wins when both fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_wr_tick <= 1'b0;
            reg_wr_idx  <= '0;
        end else begin
            reg_wr_tick <= reg_wr_c | ind_wr_tick;
            if (reg_wr_c) begin
                reg_wr_idx <= ctrl_idx_c;
            end else if (ind_wr_tick) begin
                reg_wr_idx <= ptr;
            end
        end
    end

    // VRAM address setup: low byte from the first write, high bits from the second.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vaddr      <= 14'h0000;
            vaddr_wr   <= 1'b0;
            vaddr_tick <= 1'b0;
        end else begin
            vaddr_tick <= vaddr_ld_c;
            if (vaddr_ld_c) begin
                vaddr    <= {din[5:0], w0};
                vaddr_wr <= din[6];
            end
        end
    end

endmodule
